// File: rtl/polybius_stream_ctrl.sv
// Streams ASCII characters through a Polybius-square lookup: each letter becomes
// two ASCII digits (row, column) plus an optional space; other bytes pass through.

module polybius_encrypt (
  input  logic [7:0] char_in,
  output logic [7:0] code
);
  logic [7:0] idx;

  // Binary row*10+column code for upper-case A..Z; Z shares the Y cell.
  always_comb begin
    idx  = char_in - 8'h41;
    code = 8'd0;
    if (char_in == 8'h5A) begin
      code = 8'd55;
    end else if (char_in >= 8'h41 && char_in <= 8'h59) begin
      code = (idx / 8'd5 + 8'd1) * 8'd10 + (idx % 8'd5) + 8'd1;
    end
  end
endmodule

module polybius_stream_ctrl #(
  parameter bit SEP_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] letter_count,
  input  logic             cnt_clr
);
  typedef enum logic [2:0] {
    IDLE,
    EMIT_HI,
    EMIT_LO,
    EMIT_SEP,
    EMIT_RAW
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       char_q, char_d;
  logic [CNT_W-1:0] letter_count_q, letter_count_d;

  logic [7:0] folded;
  logic       is_letter;
  logic [7:0] code;
  logic [7:0] hi;
  logic [7:0] lo;

  // The lookup sees only the registered character, so in_data never reaches out_data.
  polybius_encrypt u_encrypt (
    .char_in (char_q),
    .code    (code)
  );

  assign hi = code / 8'd10;
  assign lo = code % 8'd10;

  assign folded    = (in_data >= 8'h61 && in_data <= 8'h7A) ? in_data - 8'h20 : in_data;
  assign is_letter = (folded >= 8'h41 && folded <= 8'h5A);

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d        = state_q;
    char_d         = char_q;
    letter_count_d = letter_count_q;
    in_ready       = 1'b0;
    out_valid      = 1'b1;
    out_data       = 8'h00;

    case (state_q)
      IDLE: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        if (in_valid) begin
          char_d  = folded;
          state_d = is_letter ? EMIT_HI : EMIT_RAW;
          if (is_letter && letter_count_q != '1) begin
            letter_count_d = letter_count_q + CNT_W'(1);
          end
        end
      end
      EMIT_HI: begin
        out_data = 8'h30 + hi;
        if (out_ready) state_d = EMIT_LO;
      end
      EMIT_LO: begin
        out_data = 8'h30 + lo;
        if (out_ready) state_d = SEP_EN ? EMIT_SEP : IDLE;
      end
      EMIT_SEP: begin
        out_data = 8'h20;
        if (out_ready) state_d = IDLE;
      end
      EMIT_RAW: begin
        out_data = char_q;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        out_valid = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // A clear wins over an increment accepted in the same cycle.
    if (cnt_clr) letter_count_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      char_q         <= 8'h00;
      letter_count_q <= '0;
    end else begin
      state_q        <= state_d;
      char_q         <= char_d;
      letter_count_q <= letter_count_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign letter_count = letter_count_q;
endmodule

// File: tb/tb_polybius_stream_ctrl.sv
// Bench: two instances (separator on / CNT_W=16, separator off / CNT_W=4) checked against
// a byte-queue model of the cipher stream, plus hand-computed directed expectations.

module tb_polybius_stream_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data_a [2];
  logic [1:0] in_valid;
  logic [1:0] out_ready;
  logic [1:0] cnt_clr;

  logic        in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic [7:0]  out_data0, out_data1;
  logic [15:0] lc0;
  logic [3:0]  lc1;

  logic [1:0] in_ready_w;
  logic [1:0] out_valid_w;
  logic [1:0] busy_w;
  logic [7:0] out_data_a [2];
  int         lc_a [2];

  assign in_ready_w    = {in_ready1, in_ready0};
  assign out_valid_w   = {out_valid1, out_valid0};
  assign busy_w        = {busy1, busy0};
  assign out_data_a[0] = out_data0;
  assign out_data_a[1] = out_data1;
  assign lc_a[0]       = int'(lc0);
  assign lc_a[1]       = int'(lc1);

  always #5 clk = ~clk;

  polybius_stream_ctrl #(.SEP_EN(1'b1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data_a[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready[0]), .busy(busy0), .letter_count(lc0), .cnt_clr(cnt_clr[0])
  );

  polybius_stream_ctrl #(.SEP_EN(1'b0), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data_a[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready[1]), .busy(busy1), .letter_count(lc1), .cnt_clr(cnt_clr[1])
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [2][$];
  logic [7:0] got_q [2][$];
  int         mcnt [2];
  bit         stall [2];
  logic [7:0] stall_data [2];
  string      alpha = "ABCDEFGHIJKLMNOPQRSTUVWXY";
  int         cnt_max [2] = '{65535, 15};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: a letter's grid position gives row/column digits; anything else is echoed.
  function automatic bit model_push(int d, logic [7:0] c);
    logic [7:0] up;
    int pos;
    up  = c;
    pos = -1;
    if (c >= "a" && c <= "z") up = c - 8'h20;
    if (up == "Z") up = "Y";
    for (int i = 0; i < 25; i++) if (alpha[i] == up) pos = i;
    if (pos < 0) begin
      exp_q[d].push_back(c);
      return 1'b0;
    end
    exp_q[d].push_back(8'h30 + 8'(pos / 5 + 1));
    exp_q[d].push_back(8'h30 + 8'(pos % 5 + 1));
    if (d == 0) exp_q[d].push_back(8'h20);
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        exp_q[d].delete();
        mcnt[d]  = 0;
        stall[d] = 1'b0;
      end else begin
        check($sformatf("busy%0d", d), busy_w[d], exp_q[d].size() != 0);
        check($sformatf("out_valid%0d", d), out_valid_w[d], exp_q[d].size() != 0);
        check($sformatf("in_ready%0d", d), in_ready_w[d], exp_q[d].size() == 0);
        check($sformatf("letter_count%0d", d), lc_a[d], mcnt[d]);
        if (stall[d]) check($sformatf("hold%0d", d), out_data_a[d], stall_data[d]);
        if (out_valid_w[d] && out_ready[d]) begin
          if (exp_q[d].size() == 0) begin
            check($sformatf("unexpected_byte%0d", d), out_data_a[d], 32'hFFFF_FFFF);
          end else begin
            check($sformatf("out_byte%0d", d), out_data_a[d], exp_q[d].pop_front());
          end
          got_q[d].push_back(out_data_a[d]);
        end
        stall[d]      = out_valid_w[d] && !out_ready[d];
        stall_data[d] = out_data_a[d];
        if (in_valid[d] && in_ready_w[d]) begin
          if (model_push(d, in_data_a[d]) && mcnt[d] < cnt_max[d]) mcnt[d]++;
        end
        if (cnt_clr[d]) mcnt[d] = 0;
      end
    end
  end

  task automatic send(input int d, input logic [7:0] c, input bit clr = 1'b0);
    int n;
    n            = 0;
    in_data_a[d] = c;
    in_valid[d]  = 1'b1;
    cnt_clr[d]   = clr;
    @(negedge clk);
    while (!in_ready_w[d] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("send_ready", in_ready_w[d], 1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    cnt_clr[d]  = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((exp_q[d].size() != 0 || busy_w[d]) && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    if (n >= 100) check("drain", exp_q[d].size(), 0);
  endtask

  task automatic check_got(input int d, input string name, input logic [7:0] e [$]);
    check({name, "_len"}, got_q[d].size(), e.size());
    for (int i = 0; i < e.size() && i < got_q[d].size(); i++)
      check($sformatf("%s_%0d", name, i), got_q[d][i], e[i]);
  endtask

  initial begin
    logic [7:0] raw [4];
    raw          = '{8'h00, 8'h20, 8'h39, 8'h7B};
    rst          = 1'b1;
    in_valid     = '0;
    out_ready    = 2'b11;
    cnt_clr      = '0;
    in_data_a[0] = 8'h00;
    in_data_a[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid0, 0);
    check("rst_in_ready", in_ready0, 1);
    check("rst_out_data", out_data0, 8'h00);
    check("rst_busy", busy0, 0);
    check("rst_count", lc0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 'H' -> "23 " on consecutive cycles
    send(0, "H");
    check("h_byte0", out_data0, 8'h32);
    check("h_valid0", out_valid0, 1);
    @(posedge clk); #1;
    check("h_byte1", out_data0, 8'h33);
    @(posedge clk); #1;
    check("h_byte2", out_data0, 8'h20);
    @(posedge clk); #1;
    check("h_idle", busy0, 0);
    check("h_count", lc0, 1);

    // "az?" without separator
    got_q[1].delete();
    send(1, "a"); send(1, "z"); send(1, "?");
    drain(1);
    check_got(1, "az_q", '{8'h31, 8'h31, 8'h35, 8'h35, 8'h3F});
    check("az_count", lc1, 2);
    got_q[1].delete();
    send(1, "Y");
    drain(1);
    check_got(1, "y", '{8'h35, 8'h35});

    // Backpressure while showing the row digit of 'E'
    got_q[0].delete();
    out_ready[0] = 1'b0;
    send(0, "E");
    for (int i = 0; i < 5; i++) begin
      check("bp_data", out_data0, 8'h31);
      check("bp_valid", out_valid0, 1);
      check("bp_in_ready", in_ready0, 0);
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    drain(0);
    check_got(0, "bp", '{8'h31, 8'h35, 8'h20});
    check("bp_count", lc0, 2);

    // Non-letters echo once, no separator, count unchanged
    got_q[0].delete();
    for (int i = 0; i < 4; i++) begin
      send(0, raw[i]);
      drain(0);
    end
    check_got(0, "raw", '{8'h00, 8'h20, 8'h39, 8'h7B});
    check("raw_count", lc0, 2);

    // Asynchronous reset while emitting the column digit of 'C'
    send(0, "C");
    @(posedge clk); #1;
    check("c_lo", out_data0, 8'h33);
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid0, 0);
    check("arst_busy", busy0, 0);
    check("arst_in_ready", in_ready0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    got_q[0].delete();
    send(0, "B");
    drain(0);
    check_got(0, "b", '{8'h31, 8'h32, 8'h20});
    check("b_count", lc0, 1);

    // Saturation on the 4-bit counter, then clear racing an increment
    for (int i = 0; i < 15; i++) send(1, "A");
    drain(1);
    check("sat_15", lc1, 15);
    send(1, "b");
    drain(1);
    check("sat_hold", lc1, 15);
    send(1, "C", 1'b1);
    drain(1);
    check("clr_prio", lc1, 0);

    drain(0);
    drain(1);
    check("final_q0", exp_q[0].size(), 0);
    check("final_q1", exp_q[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
